pwm_dac: RTL and testbench

//  Digital-to-analog output stage. It is the return path to the SAR ADC.
//  - Accepts N-bit codes through a valid/ready write port and buffers them in a small FIFO.
//  - Renders each code as one PWM period of 2^N clocks. An external RC filter turns this into a voltage.
//  - Reports the nominal millivolt value of the code being played, using the same VREF/2^N resolution as the ADC.

---
 rtl/pwm_dac_pkg.sv | 26 ++
 rtl/dac_code_fifo.sv | 50 +++++
 rtl/pwm_dac.sv | 95 +++++++++
 tb/tb_pwm_dac.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dac_pkg.sv
// Shared constants and helpers for the PWM DAC output stage.
// Resolution and counter limits are derived from the top-level parameters.
package pwm_dac_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  typedef enum logic {
    StIdle = IDLE,
    StRun  = RUN
  } state_e;

  localparam int unsigned DefN    = 10;
  localparam int unsigned DefVref = 5000;
  localparam int unsigned RESO    = DefVref / (32'd1 << DefN);

  // mV per LSB, truncated; matches the ADC's VREF/2^N step.
  function automatic int unsigned calc_reso(input int unsigned vref, input int unsigned n);
    return vref / (32'd1 << n);
  endfunction

  function automatic int unsigned cnt_max(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/dac_code_fifo.sv
// Synchronous code FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguished by comparing the pointer MSBs.
module dac_code_fifo
  import pwm_dac_pkg::*;
#(
  parameter int unsigned N     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [N-1:0] din,
  input  logic         pop,
  output logic [N-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic [N-1:0] mem_q [DEPTH];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop && !empty) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: emptied pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC output stage: buffers N-bit codes, plays each as one 2^N-clock PWM
// period and reports the nominal millivolt value of the code being played.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int unsigned N     = 10,
  parameter int unsigned VREF  = 5000,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MVW   = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           wr_valid,
  input  logic [N-1:0]   din,
  output logic           wr_ready,
  output logic           pwm_out,
  output logic           busy,
  output logic           period_done,
  output logic           repeat_code,
  output logic [MVW-1:0] vout_mv
);

  localparam int unsigned LsbMv  = calc_reso(VREF, N);
  localparam logic [N-1:0] CntMax = N'(cnt_max(N));

  state_e         state_q;
  logic [N-1:0]   cnt_q;
  logic [N-1:0]   cur_code_q;
  logic [MVW-1:0] vout_q;

  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic [N-1:0]   fifo_dout;
  logic           at_end;
  logic [N+15:0]  prod;

  dac_code_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_valid),
    .din   (din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign at_end   = (state_q == StRun) && (cnt_q == CntMax);
  // Codes are only taken from IDLE or at a period boundary, never mid-period.
  assign fifo_pop = en && !fifo_empty && ((state_q == StIdle) || at_end);
  assign prod     = (N+16)'(cur_code_q) * (N+16)'(LsbMv);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cur_code_q <= '0;
      vout_q     <= '0;
    end else begin
      vout_q <= MVW'(prod);
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (fifo_pop) begin
            cur_code_q <= fifo_dout;
            state_q    <= StRun;
          end
        end
        StRun: begin
          cnt_q <= cnt_q + 1'b1;
          if (at_end) begin
            if (!en) begin
              state_q <= StIdle;
            end else if (fifo_pop) begin
              cur_code_q <= fifo_dout;
            end
          end
        end
      endcase
    end
  end

  assign wr_ready    = !fifo_full;
  assign busy        = (state_q == StRun);
  assign pwm_out     = (state_q == StRun) && (cnt_q < cur_code_q);
  assign period_done = at_end;
  assign repeat_code = at_end && en && fifo_empty;
  assign vout_mv     = vout_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac with N=4, VREF=5000, DEPTH=4 against a
// queue-based behavioural model of the playback rules.
module tb_pwm_dac;

  localparam int N       = 4;
  localparam int VREF    = 5000;
  localparam int DEPTH   = 4;
  localparam int MVW     = 16;
  localparam int PER     = 16;
  localparam int RESO_TB = VREF / PER;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           en = 1'b0;
  logic           wr_valid = 1'b0;
  logic [N-1:0]   din = '0;
  logic           wr_ready;
  logic           pwm_out;
  logic           busy;
  logic           period_done;
  logic           repeat_code;
  logic [MVW-1:0] vout_mv;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_dac #(
    .N     (N),
    .VREF  (VREF),
    .DEPTH (DEPTH),
    .MVW   (MVW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .wr_valid    (wr_valid),
    .din         (din),
    .wr_ready    (wr_ready),
    .pwm_out     (pwm_out),
    .busy        (busy),
    .period_done (period_done),
    .repeat_code (repeat_code),
    .vout_mv     (vout_mv)
  );

  // Reference model: a code queue, the code being played and the position in its period.
  int m_q[$];
  bit m_playing = 1'b0;
  int m_pos = 0;
  int m_code = 0;
  int m_mv = 0;

  always @(posedge clk) begin : model
    int sz;
    sz = m_q.size();
    if (reset) begin
      m_q.delete();
      m_playing = 1'b0;
      m_pos = 0;
      m_code = 0;
      m_mv = 0;
    end else begin
      m_mv = (m_code * RESO_TB) % 65536;
      if (!m_playing) begin
        if (en && sz > 0) begin
          m_code = m_q.pop_front();
          m_playing = 1'b1;
          m_pos = 0;
        end
      end else if (m_pos == PER - 1) begin
        m_pos = 0;
        if (!en) m_playing = 1'b0;
        else if (sz > 0) m_code = m_q.pop_front();
      end else begin
        m_pos++;
      end
      if (wr_valid && sz < DEPTH) m_q.push_back(int'(din));
    end
  end

  logic [20:0] obs;
  assign obs = {pwm_out, busy, period_done, repeat_code, wr_ready, vout_mv};

  function automatic logic [20:0] model_out();
    logic d;
    logic [15:0] mv;
    d  = m_playing && (m_pos == PER - 1);
    mv = 16'(m_mv);
    return {m_playing && (m_pos < m_code), m_playing, d, d && en && (m_q.size() == 0),
            m_q.size() < DEPTH, mv};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== {5'b00001, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, {5'b00001, 16'd0});
    end
    n_checks++;
    if (obs !== model_out()) begin
      n_fail++;
      $display("FAIL reset_model: got %h want %h", obs, model_out());
    end
  endtask

  task automatic test_basic_duty();
    bit ok;
    int highs, dones, bad_done;
    do_reset();
    wr_valid = 1'b1; din = 4'd5; en = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_busy(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_start: busy never rose"); end
    highs = 0; dones = 0; bad_done = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL basic_model cyc %0d: got %h want %h", i, obs, model_out());
      end
      if (i < PER && pwm_out) highs++;
      if (period_done) dones++;
      if (period_done !== (i % PER == PER - 1)) bad_done++;
      @(negedge clk);
    end
    n_checks++;
    if (highs != 5) begin n_fail++; $display("FAIL basic_highs: got %0d want 5", highs); end
    n_checks++;
    if (dones != 3 || bad_done != 0) begin
      n_fail++;
      $display("FAIL basic_done: got %0d pulses (%0d misplaced) want 3", dones, bad_done);
    end
    n_checks++;
    if (vout_mv !== 16'd1560) begin
      n_fail++;
      $display("FAIL basic_vout: got %0d want 1560", vout_mv);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] got, want;
    do_reset();
    wr_valid = 1'b1; din = 4'd0; en = 1'b1;
    @(negedge clk);
    din = 4'd15;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_busy(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_start: busy never rose"); end
    for (int i = 0; i < 2 * PER; i++) begin
      got[i]  = pwm_out;
      want[i] = (i >= PER) && (i - PER < 15);
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL b2b_model cyc %0d: got %h want %h", i, obs, model_out());
      end
      @(negedge clk);
    end
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL b2b_wave: got %b want %b", got, want);
    end
  endtask

  task automatic test_fill_full();
    bit ok;
    logic [5:0] rdy;
    int h;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      rdy[k] = wr_ready;
      wr_valid = 1'b1;
      din = 4'(k + 1);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    n_checks++;
    if (rdy !== 6'b001111) begin
      n_fail++;
      $display("FAIL full_ready: got %b want %b", rdy, 6'b001111);
    end
    en = 1'b1;
    wait_busy(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_start: busy never rose"); end
    for (int p = 0; p < 5; p++) begin
      h = 0;
      for (int i = 0; i < PER; i++) begin
        n_checks++;
        if (obs !== model_out()) begin
          n_fail++;
          $display("FAIL full_model p%0d cyc %0d: got %h want %h", p, i, obs, model_out());
        end
        if (pwm_out) h++;
        @(negedge clk);
      end
      n_checks++;
      if (h != ((p < 4) ? p + 1 : 4)) begin
        n_fail++;
        $display("FAIL full_order p%0d: got %0d want %0d", p, h, (p < 4) ? p + 1 : 4);
      end
    end
  endtask

  task automatic test_repeat();
    bit ok;
    int highs, dones, bad;
    do_reset();
    wr_valid = 1'b1; din = 4'd9; en = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_busy(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rep_start: busy never rose"); end
    highs = 0; dones = 0; bad = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL rep_model cyc %0d: got %h want %h", i, obs, model_out());
      end
      if (pwm_out) highs++;
      if (period_done) dones++;
      if (repeat_code !== period_done) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0 || dones != 3) begin
      n_fail++;
      $display("FAIL rep_pulse: got %0d dones %0d mismatches want 3 and 0", dones, bad);
    end
    n_checks++;
    if (highs != 27) begin n_fail++; $display("FAIL rep_highs: got %0d want 27", highs); end
  endtask

  task automatic test_en_drop();
    bit ok;
    int highs;
    logic [2:0] edge_obs;
    do_reset();
    wr_valid = 1'b1; din = 4'd7; en = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_busy(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drop_start: busy never rose"); end
    highs = 0;
    edge_obs = '0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL drop_model cyc %0d: got %h want %h", i, obs, model_out());
      end
      if (pwm_out) highs++;
      if (i == PER - 1) edge_obs[2:1] = {busy, period_done};
      if (i == PER) edge_obs[0] = busy | pwm_out;
      if (i == 3) en = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (edge_obs !== 3'b110 || highs != 7) begin
      n_fail++;
      $display("FAIL drop_complete: got %b highs %0d want 110 highs 7", edge_obs, highs);
    end
    n_checks++;
    if ({busy, pwm_out, vout_mv} !== {2'b00, 16'd2184}) begin
      n_fail++;
      $display("FAIL drop_idle: got busy %b pwm %b mv %0d want 0 0 2184", busy, pwm_out, vout_mv);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int dones, busy_after;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      din = (k == 0) ? 4'd11 : 4'(k + 1);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    en = 1'b1;
    wait_busy(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mrst_start: busy never rose"); end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (period_done) dones++;
      if (i == 7) reset = 1'b1;
      @(negedge clk);
    end
    if (period_done) dones++;
    n_checks++;
    if (obs !== {5'b00001, 16'd0}) begin
      n_fail++;
      $display("FAIL mrst_state: got %h want %h", obs, {5'b00001, 16'd0});
    end
    reset = 1'b0;
    busy_after = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || period_done) busy_after++;
    end
    n_checks++;
    if (dones != 0 || busy_after != 0) begin
      n_fail++;
      $display("FAIL mrst_discard: got %0d dones %0d busy cycles want 0 0", dones, busy_after);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL rand_model cyc %0d: got %h want %h", i, obs, model_out());
      end
      wr_valid = ($urandom_range(0, 2) == 0);
      din      = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 7) != 0);
      reset    = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_back_to_back();
    test_fill_full();
    test_repeat();
    test_en_drop();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
